counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of counter, load value and count output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level sampled each edge; begins a run from IDLE or resumes from PAUSE.
REQ-005 stop  input  1  aborts any run; returns to IDLE.
REQ-006 pause  input  1  freezes a run in progress.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic; sampled only when start is accepted in IDLE.
REQ-008 load_val  input  WIDTH  terminal-count value; sampled only when start is accepted in IDLE.
REQ-009 count  output  WIDTH  current down-counter value, registered.
REQ-010 done  output  1  one-cycle pulse, registered, on terminal count.
REQ-011 busy  output  1  high when state is RUN or PAUSE.
REQ-012 paused  output  1  high when state is PAUSE.

Function
REQ-013 FSM states: IDLE, RUN, PAUSE; all outputs registered or decoded from registered state only.
REQ-014 Input priority at each edge: stop > pause > start.
REQ-015 IDLE + start, load_val != 0: count <= load_val; reload register <= load_val; mode latched; next state RUN.
REQ-016 IDLE + start, load_val == 0: done pulses for one cycle; count <= 0; state stays IDLE; busy never asserts.
REQ-017 RUN, count > 1: count decrements by 1 per edge.
REQ-018 RUN, count == 1, latched mode 0: count <= 0; done <= 1; next state IDLE.
REQ-019 RUN, count == 1, latched mode 1: count <= reload register; done <= 1; state stays RUN. The period is therefore exactly load_val cycles.
REQ-020 RUN + pause: next state PAUSE; count holds; no decrement on that edge.
REQ-021 PAUSE: count holds. start -> RUN, with decrement resuming on the following edge. pause is ignored in PAUSE.
REQ-022 RUN or PAUSE + stop: next state IDLE; count <= 0; no done pulse, even if count == 1 on that edge.
REQ-023 start while in RUN is ignored: no restart, and load_val and mode are not resampled.
REQ-024 In IDLE without an accepted start: count holds its value; done = 0.
REQ-025 done is never high for two consecutive cycles except in periodic mode with load_val == 1, where it stays high every cycle.
REQ-026 Counter arithmetic is modulo 2^WIDTH unsigned; no underflow is possible because count is never decremented at 0.

Reset
REQ-027 rst high at an edge: state <= IDLE, count <= 0, done <= 0, reload <= 0, latched mode <= 0.
REQ-028 rst takes priority over all other inputs, including a start in the same cycle and a run in progress; no done pulse is produced.

Structure
REQ-029 A shared package holds the state enum (IDLE, RUN, PAUSE) and the default WIDTH constant.
REQ-030 One sub-module, down_counter: a WIDTH-bit register with load, enable and zero-detect ports; counter_ctrl contains the FSM and reload register.

Verification
REQ-031 Reset: assert rst 2 cycles -> count=0, done=0, busy=0, paused=0.
REQ-032 One-shot, load_val=3, start at edge E0 -> count 3,2,1,0 after E0..E3; done=1 only after E3; busy falls after E3.
REQ-033 Periodic, load_val=2 -> count 2,1,2,1,2; done high after E2 and E4 only; busy stays 1.
REQ-034 Pause and resume, one-shot load_val=5:
- pause after count=3 -> count held at 3 for 4 cycles with paused=1;
- start -> count 2,1,0; done once.
REQ-035 Abort and zero-load edge cases:
- stop with count=1 -> count=0, IDLE, no done.
- load_val=0 + start -> done pulse 1 cycle, busy stays 0.
REQ-036 Reset during a periodic run (count=4) -> next cycle count=0, IDLE, no done; a following start with load_val=2 behaves as in REQ-033.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter controller.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_ctrl_down_counter.sv
// WIDTH-bit down-counter with synchronous load, enable and zero/one detect.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o,
  output logic             one_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over enable; the counter never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
  assign one_o   = (count_q == WIDTH'(1));

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/stop controller around a down-counter, with one-shot and
// periodic modes and a registered terminal-count pulse.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             busy,
  output logic             paused
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic             cnt_one;

  down_counter #(.WIDTH(WIDTH)) u_down_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .count_o    (count),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    mode_d       = mode_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // pause has nothing to freeze here, so only stop can block a start.
        if (!stop && start) begin
          if (load_val == '0) begin
            cnt_load = 1'b1;
            done_d   = 1'b1;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = load_val;
            reload_d     = load_val;
            mode_d       = mode;
            state_d      = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          cnt_load = 1'b1;
          state_d  = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (cnt_one) begin
          done_d   = 1'b1;
          cnt_load = 1'b1;
          if (mode_q) begin
            cnt_load_val = reload_q;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          cnt_load = 1'b1;
          state_d  = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: begin
        cnt_load = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign busy   = (state_q == RUN) || (state_q == PAUSE);
  assign paused = (state_q == PAUSE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed vector table, hand sequences and a
// randomized run against a behavioural model.
module tb_counter_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, stop, pause, mode;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         done, busy, paused;

  int n_vec = 0;
  int n_err = 0;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .done     (done),
    .busy     (busy),
    .paused   (paused)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         r, s, sp, p, m;
    logic [7:0] lv;
    logic [7:0] c;
    bit         d, b, pa;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input bit r, input bit s, input bit sp,
                     input bit p, input bit m, input int lv,
                     input int c, input bit d, input bit b, input bit pa);
    vec_t v;
    v.name = nm; v.r = r; v.s = s; v.sp = sp; v.p = p; v.m = m;
    v.lv = 8'(lv); v.c = 8'(c); v.d = d; v.b = b; v.pa = pa;
    tbl.push_back(v);
  endtask

  task automatic step(input bit r, input bit s, input bit sp, input bit p,
                      input bit m, input logic [7:0] lv);
    rst = r; start = s; stop = sp; pause = p; mode = m; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] c, input bit d,
                       input bit b, input bit pa);
    n_vec++;
    if (count !== c || done !== d || busy !== b || paused !== pa) begin
      n_err++;
      $display("FAIL %s: got count=%0d done=%0b busy=%0b paused=%0b, want count=%0d done=%0b busy=%0b paused=%0b",
               nm, count, done, busy, paused, c, d, b, pa);
    end
  endtask

  // Behavioural model: a remaining-cycles number plus run/freeze flags.
  int  m_left;
  bit  m_active, m_frozen, m_repeat, m_done;
  int  m_period;

  task automatic model(input bit r, input bit s, input bit sp, input bit p,
                       input bit m, input int lv);
    m_done = 0;
    if (r) begin
      m_left = 0; m_active = 0; m_frozen = 0; m_repeat = 0; m_period = 0;
    end else if (!m_active && !m_frozen) begin
      if (s && !sp) begin
        if (lv == 0) begin
          m_left = 0; m_done = 1;
        end else begin
          m_left = lv; m_period = lv; m_repeat = m; m_active = 1;
        end
      end
    end else if (sp) begin
      m_left = 0; m_active = 0; m_frozen = 0;
    end else if (m_frozen) begin
      if (s) begin m_frozen = 0; m_active = 1; end
    end else if (p) begin
      m_frozen = 1; m_active = 0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1;
        if (m_repeat) m_left = m_period;
        else m_active = 0;
      end
    end
  endtask

  initial begin
    rst = 0; start = 0; stop = 0; pause = 0; mode = 0; load_val = '0;

    //      name          r s sp p m lv   c d b pa
    add("reset1",         1,0,0,0,0, 0,   0,0,0,0);
    add("reset2",         1,0,0,0,0, 0,   0,0,0,0);
    add("os_start",       0,1,0,0,0, 3,   3,0,1,0);
    add("os_dec2",        0,0,0,0,0, 0,   2,0,1,0);
    add("os_dec1",        0,0,0,0,0, 0,   1,0,1,0);
    add("os_done",        0,0,0,0,0, 0,   0,1,0,0);
    add("os_idle",        0,0,0,0,0, 0,   0,0,0,0);
    add("per_start",      0,1,0,0,1, 2,   2,0,1,0);
    add("per_ign_start",  0,1,0,0,0, 9,   1,0,1,0);
    add("per_reload1",    0,0,0,0,0, 0,   2,1,1,0);
    add("per_dec",        0,0,0,0,0, 0,   1,0,1,0);
    add("per_reload2",    0,0,0,0,0, 0,   2,1,1,0);
    add("per_stop",       0,0,1,0,0, 0,   0,0,0,0);
    add("pr_start",       0,1,0,0,0, 5,   5,0,1,0);
    add("pr_dec4",        0,0,0,0,0, 0,   4,0,1,0);
    add("pr_dec3",        0,0,0,0,0, 0,   3,0,1,0);
    add("pr_pause",       0,0,0,1,0, 0,   3,0,1,1);
    add("pr_hold2",       0,0,0,0,0, 0,   3,0,1,1);
    add("pr_hold3_pause", 0,0,0,1,0, 0,   3,0,1,1);
    add("pr_hold4",       0,0,0,0,0, 0,   3,0,1,1);
    add("pr_resume",      0,1,0,0,1, 7,   3,0,1,0);
    add("pr_dec2",        0,0,0,0,0, 0,   2,0,1,0);
    add("pr_dec1",        0,0,0,0,0, 0,   1,0,1,0);
    add("pr_done",        0,0,0,0,0, 0,   0,1,0,0);
    add("ab_start",       0,1,0,0,0, 2,   2,0,1,0);
    add("ab_dec1",        0,0,0,0,0, 0,   1,0,1,0);
    add("ab_stop_at1",    0,0,1,0,0, 0,   0,0,0,0);
    add("ab_idle",        0,0,0,0,0, 0,   0,0,0,0);
    add("zero_load",      0,1,0,0,0, 0,   0,1,0,0);
    add("zero_after",     0,0,0,0,0, 0,   0,0,0,0);
    add("p1_start",       0,1,0,0,1, 1,   1,0,1,0);
    add("p1_done_a",      0,0,0,0,0, 0,   1,1,1,0);
    add("p1_done_b",      0,0,0,0,0, 0,   1,1,1,0);
    add("p1_stop",        0,0,1,0,0, 0,   0,0,0,0);
    add("rst_over_start", 1,1,0,0,0, 4,   0,0,0,0);
    add("stop_over_start",0,1,1,0,0, 4,   0,0,0,0);
    add("ps_start",       0,1,0,0,0, 4,   4,0,1,0);
    add("ps_pause",       0,0,0,1,0, 0,   4,0,1,1);
    add("ps_stop",        0,0,1,0,0, 0,   0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].p, tbl[i].m, tbl[i].lv);
      check(tbl[i].name, tbl[i].c, tbl[i].d, tbl[i].b, tbl[i].pa);
    end

    // Reset in the middle of a periodic run, then a clean periodic restart.
    step(0,1,0,0,1,8'd6); check("rp_start", 6,0,1,0);
    step(0,0,0,0,0,8'd0); check("rp_dec5",  5,0,1,0);
    step(0,0,0,0,0,8'd0); check("rp_dec4",  4,0,1,0);
    step(1,0,0,0,0,8'd0); check("rp_reset", 0,0,0,0);
    step(0,0,0,0,0,8'd0); check("rp_idle",  0,0,0,0);
    step(0,1,0,0,1,8'd2); check("rp_re2",   2,0,1,0);
    step(0,0,0,0,0,8'd0); check("rp_re1",   1,0,1,0);
    step(0,0,0,0,0,8'd0); check("rp_rel1",  2,1,1,0);
    step(0,0,0,0,0,8'd0); check("rp_re1b",  1,0,1,0);
    step(0,0,0,0,0,8'd0); check("rp_rel2",  2,1,1,0);

    // Randomized run against the model, starting from a reset.
    model(1,0,0,0,0,0);
    step(1,0,0,0,0,8'd0);
    check("rnd_reset", 8'(m_left), m_done, m_active | m_frozen, m_frozen);
    for (int i = 0; i < 4000; i++) begin
      bit r, s, sp, p, m;
      int lv;
      r  = ($urandom_range(0, 99) == 0);
      sp = ($urandom_range(0, 19) == 0);
      p  = ($urandom_range(0, 9) == 0);
      s  = ($urandom_range(0, 3) == 0);
      m  = 1'($urandom_range(0, 1));
      lv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 6));
      model(r, s, sp, p, m, lv);
      step(r, s, sp, p, m, 8'(lv));
      check("rnd", 8'(m_left), m_done, m_active | m_frozen, m_frozen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
